fb_pixel_writer: RTL
====================

# fb_pixel_writer

Consumes the pixel stream produced by the line rasterizer (x, y, valid strobe) and turns it into framebuffer write transactions. Provides backpressure through `pixel_ready`, which drives the rasterizer's `oe` input. Buffers pixels in a small FIFO, clips off-screen coordinates, and computes linear addresses. Also performs a full-screen clear sweep on request. Sits between the rasterizer and the framebuffer memory arbiter.

## Interface
- COORD_WIDTH, 16, signed coordinate width; matches the rasterizer.
- FB_WIDTH, 320, framebuffer width in pixels.
- FB_HEIGHT, 180, framebuffer height in pixels.
- COLOR_WIDTH, 8, pixel data width.
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2.
- ADDR_WIDTH (localparam) = $clog2(FB_WIDTH*FB_HEIGHT).

Ports:
- clk_in  in  1  sole clock; all logic on the rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- pixel_valid  in  1  pixel present; driven by the rasterizer's `drawing`.
- x_in, y_in  in  COORD_WIDTH (signed)  pixel coordinate.
- color_in  in  COLOR_WIDTH  pixel color.
- pixel_ready  out  1  pixel accepted when valid && ready; drives the rasterizer's `oe`.
- clear_start  in  1  single-cycle pulse requesting a full-screen clear.
- clear_color  in  COLOR_WIDTH  fill value; sampled with clear_start.
- fb_addr  out  ADDR_WIDTH  write address.
- fb_data  out  COLOR_WIDTH  write data.
- fb_we  out  1  write request.
- fb_ready  in  1  memory accepts the write when fb_we && fb_ready.
- busy  out  1  high in DRAIN or CLEAR, or when any FIFO/pipeline entry is valid.
- clip_count  out  32  present only with FB_CLIP_STATS_EN.

## Operation
- FSM states: RUN, DRAIN, CLEAR. Reset state is RUN.
- RUN:
  - pixel_ready = (fifo_count < FIFO_DEPTH), derived from registered state only; there is no combinational path from pixel_valid.
  - clear_start → DRAIN; latches clear_color.
- DRAIN:
  - pixel_ready = 0.
  - Existing FIFO and pipeline entries complete normally.
  - When the FIFO is empty and no stage is valid → CLEAR, with sweep address 0.
- CLEAR:
  - pixel_ready = 0.
  - Issues fb_we with fb_addr = sweep address and fb_data = latched color.
  - The sweep address increments on each accepted write.
  - After address FB_WIDTH*FB_HEIGHT-1 is accepted → RUN.
- clear_start is ignored outside RUN.
- Pixel pipeline (RUN/DRAIN):
  - FIFO head → stage S1: clip test, then addr = y*FB_WIDTH + x.
  - S1 → output register (fb_addr/fb_data/fb_we).
- Clip rule: a pixel is discarded at S1, producing no write, if x<0, x≥FB_WIDTH, y<0 or y≥FB_HEIGHT.
  - The comparison is done on signed COORD_WIDTH+1 values.
  - The address is computed unsigned, only for in-range pixels.
- Stall: while fb_we && !fb_ready, the output register, S1 and FIFO pop all hold. The FIFO may still accept pushes while not full.
- Full with simultaneous pop: pixel_ready is already low, so no push occurs; the pop proceeds.
- Reset (any time, including mid-clear):
  - FIFO emptied, stages invalidated, state RUN.
  - fb_we=0, fb_addr=0, fb_data=0, busy=0, pixel_ready=1, clip_count=0.

## Timing
- Latency: a pixel accepted at edge N into an empty FIFO with fb_ready=1 appears on fb_we after edge N+2. That is 2 cycles.
- Throughput: one pixel per cycle sustained while fb_ready=1.
- Clear: FB_WIDTH*FB_HEIGHT cycles plus fb_ready stalls.
- Clear start: the first clear write is asserted one cycle after the DRAIN→CLEAR transition.
- Backpressure: pixel_ready falls in the cycle after the push that fills the FIFO.
- The rasterizer holds x/y while oe=0, so no pixel is lost or duplicated.

## Configuration
- FB_CLIP_STATS_EN defined:
  - clip_count increments (saturating at 2^32-1) for each pixel discarded at S1.
  - Cleared only by reset.
- FB_CLIP_STATS_EN not defined: the clip_count port and counter are absent. All other behaviour is identical.

## Test plan
- Single pixel (5,3), color 0x2A, fb_ready=1 → one write 2 cycles later with fb_addr=3*320+5=965 and fb_data=0x2A. busy then drops.
- Line stream of 10 pixels with fb_ready held 0 for 8 cycles → pixel_ready low after 4 accepts plus pipeline fill. Once fb_ready returns, all 10 writes occur in order with no loss or duplicates.
- Pixels (-1,0), (320,5), (0,180), (319,179):
  - Only (319,179) writes, at addr 57599.
  - clip_count=3 with FB_CLIP_STATS_EN.
- clear_start with color 0x11 while 3 pixels are queued:
  - The 3 pixel writes complete first.
  - Then 57600 writes at addr 0..57599 with data 0x11, with pixel_ready=0 throughout.
  - Then back to RUN.
- Reset asserted mid-clear at sweep address 1000 → fb_we drops immediately (asynchronously) and pixel_ready=1. The next pixel writes normally.
- clear_start pulsed during CLEAR → ignored; exactly one sweep is performed.

Source files
------------

// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: pixel stream, clear request and framebuffer write bus.
// clip_count exists only when FB_CLIP_STATS_EN is defined.
interface fb_pixel_writer_if #(
   parameter int COORD_WIDTH = 16,
   parameter int COLOR_WIDTH = 8,
   parameter int ADDR_WIDTH  = 16
);
   logic                          pixel_valid;
   logic signed [COORD_WIDTH-1:0] x_in;
   logic signed [COORD_WIDTH-1:0] y_in;
   logic [COLOR_WIDTH-1:0]        color_in;
   logic                          pixel_ready;
   logic                          clear_start;
   logic [COLOR_WIDTH-1:0]        clear_color;
   logic [ADDR_WIDTH-1:0]         fb_addr;
   logic [COLOR_WIDTH-1:0]        fb_data;
   logic                          fb_we;
   logic                          fb_ready;
   logic                          busy;
`ifdef FB_CLIP_STATS_EN
   logic [31:0]                   clip_count;
`endif

   // Environment side: rasterizer, clear requester and memory arbiter.
   modport master (
`ifdef FB_CLIP_STATS_EN
      input  clip_count,
`endif
      output pixel_valid, x_in, y_in, color_in,
      input  pixel_ready,
      output clear_start, clear_color,
      input  fb_addr, fb_data, fb_we,
      output fb_ready,
      input  busy
   );

   // Pixel writer side.
   modport slave (
`ifdef FB_CLIP_STATS_EN
      output clip_count,
`endif
      input  pixel_valid, x_in, y_in, color_in,
      output pixel_ready,
      input  clear_start, clear_color,
      output fb_addr, fb_data, fb_we,
      input  fb_ready,
      output busy
   );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: buffers rasterizer pixels, clips, addresses and writes
// them to the framebuffer; also sweeps a full-screen clear. Optional
// macro FB_CLIP_STATS_EN adds a saturating clip_count.
module fb_pixel_writer #(
   parameter int COORD_WIDTH = 16,
   parameter int FB_WIDTH    = 320,
   parameter int FB_HEIGHT   = 180,
   parameter int COLOR_WIDTH = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input logic              clk_in,
   input logic              rst_in,
   fb_pixel_writer_if.slave bus
);
   localparam int NPIX       = FB_WIDTH * FB_HEIGHT;
   localparam int ADDR_WIDTH = $clog2(NPIX);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CW         = COORD_WIDTH;

   localparam logic signed [CW:0] W_S = (CW+1)'(FB_WIDTH);
   localparam logic signed [CW:0] H_S = (CW+1)'(FB_HEIGHT);
   localparam logic [ADDR_WIDTH:0] SWEEP_END = (ADDR_WIDTH+1)'(NPIX);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_e;

   state_e state_q, state_d;

   logic signed [CW-1:0]   fx_q [FIFO_DEPTH];
   logic signed [CW-1:0]   fy_q [FIFO_DEPTH];
   logic [COLOR_WIDTH-1:0] fc_q [FIFO_DEPTH];
   logic [PTR_W:0]         wr_ptr_q, rd_ptr_q, count;
   logic [PTR_W-1:0]       wr_idx, rd_idx;

   logic                   s1_vld_q;
   logic signed [CW-1:0]   s1_x_q, s1_y_q;
   logic [COLOR_WIDTH-1:0] s1_c_q;

   logic                   out_vld_q, out_vld_d;
   logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
   logic [COLOR_WIDTH-1:0] out_data_q, out_data_d;

   logic [ADDR_WIDTH:0]    sweep_q, sweep_d;
   logic [COLOR_WIDTH-1:0] clr_color_q;

   logic                   stall, adv, fifo_empty, push, pop;
   logic                   accept, sweep_done, inrange;
   logic signed [CW:0]     sx, sy;
   logic [ADDR_WIDTH-1:0]  s1_addr;

   assign wr_idx     = wr_ptr_q[PTR_W-1:0];
   assign rd_idx     = rd_ptr_q[PTR_W-1:0];
   assign count      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (count == '0);

   // A held write freezes the output register, S1 and the FIFO pop.
   assign stall  = out_vld_q && !bus.fb_ready;
   assign adv    = !stall;
   assign accept = out_vld_q && bus.fb_ready;
   assign push   = bus.pixel_valid && bus.pixel_ready;
   assign pop    = adv && !fifo_empty;

   // Sign-extend by one bit so the bound compares cannot wrap.
   assign sx = {s1_x_q[CW-1], s1_x_q};
   assign sy = {s1_y_q[CW-1], s1_y_q};
   assign inrange = !sx[CW] && (sx < W_S) && !sy[CW] && (sy < H_S);
   assign s1_addr = inrange
      ? ADDR_WIDTH'($unsigned(s1_y_q)) * ADDR_WIDTH'(FB_WIDTH)
        + ADDR_WIDTH'($unsigned(s1_x_q))
      : '0;

   assign sweep_done = (sweep_q == SWEEP_END);

   assign bus.pixel_ready = (state_q == RUN) && (count < DEPTH_C);
   assign bus.fb_we   = out_vld_q;
   assign bus.fb_addr = out_addr_q;
   assign bus.fb_data = out_data_q;
   assign bus.busy    = (state_q != RUN) || !fifo_empty
                        || s1_vld_q || out_vld_q;

   // State register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Mode sequencing: drain queued pixels before the clear sweep.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:
            if (bus.clear_start) state_d = DRAIN;
         DRAIN:
            if (fifo_empty && !s1_vld_q && !out_vld_q) state_d = CLEAR;
         CLEAR:
            if (sweep_done && accept) state_d = RUN;
         default:
            state_d = RUN;
      endcase
   end

   // FIFO pointers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents are qualified by the pointers.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fx_q[wr_idx] <= bus.x_in;
         fy_q[wr_idx] <= bus.y_in;
         fc_q[wr_idx] <= bus.color_in;
      end
   end

   // S1 takes the FIFO head whenever the pipeline advances.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_vld_q <= 1'b0;
         s1_x_q   <= '0;
         s1_y_q   <= '0;
         s1_c_q   <= '0;
      end else if (adv) begin
         s1_vld_q <= !fifo_empty;
         s1_x_q   <= fx_q[rd_idx];
         s1_y_q   <= fy_q[rd_idx];
         s1_c_q   <= fc_q[rd_idx];
      end
   end

   // Output register source: clipped pixels in RUN/DRAIN, sweep in CLEAR.
   always_comb begin
      out_vld_d  = out_vld_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      sweep_d    = sweep_q;
      if (state_q == DRAIN && state_d == CLEAR) sweep_d = '0;
      if (adv) begin
         if (state_q == CLEAR) begin
            out_vld_d = !sweep_done;
            if (!sweep_done) begin
               out_addr_d = sweep_q[ADDR_WIDTH-1:0];
               out_data_d = clr_color_q;
               sweep_d    = sweep_q + 1'b1;
            end
         end else begin
            out_vld_d = s1_vld_q && inrange;
            if (s1_vld_q && inrange) begin
               out_addr_d = s1_addr;
               out_data_d = s1_c_q;
            end
         end
      end
   end

   // Output register and sweep counter.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         out_vld_q  <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
         sweep_q    <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         sweep_q    <= sweep_d;
      end
   end

   // Fill colour is captured with the accepted clear request.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         clr_color_q <= '0;
      else if (state_q == RUN && bus.clear_start)
         clr_color_q <= bus.clear_color;
   end

`ifdef FB_CLIP_STATS_EN
   logic        clip_hit;
   logic [31:0] clip_cnt_q;

   assign clip_hit       = adv && s1_vld_q && !inrange;
   assign bus.clip_count = clip_cnt_q;

   // Saturating count of pixels dropped by the clip test.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         clip_cnt_q <= '0;
      else if (clip_hit && clip_cnt_q != '1)
         clip_cnt_q <= clip_cnt_q + 1'b1;
   end
`else
   // Without statistics, clipped pixels are dropped silently.
`endif

endmodule
